// File: rtl/encoder_mac_seq.sv
// Sequential dense layer: one shared signed MAC, round-half-up and saturation; latency M_output*(N_input+1) cycles from accept.
// Accepts one bundle only in IDLE; y is held in DONE until out_ready. Define ENCODER_RELU_EN to clamp negative results to zero.
module encoder_mac_seq #(
  parameter int N_input  = 9,
  parameter int M_output = 4,
  parameter int BITSIZE  = 32,
  parameter int FRAC     = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [N_input*BITSIZE-1:0]           x,
  input  logic [N_input*M_output*BITSIZE-1:0]  w,
  input  logic [M_output*BITSIZE-1:0]          b,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [M_output*BITSIZE-1:0]          y,
  output logic                                 busy
);

  localparam int IW = (N_input > 1) ? $clog2(N_input) : 1;
  localparam int JW = (M_output > 1) ? $clog2(M_output) : 1;
  localparam int PW = 2 * BITSIZE;
  localparam int AW = 2 * BITSIZE + $clog2(N_input) + 1;
  localparam int TW = AW + 1;

  localparam logic signed [TW-1:0] RND     = $signed(TW'(1) << (FRAC - 1));
  localparam logic signed [TW-1:0] SAT_MAX = $signed((TW'(1) << (BITSIZE - 1)) - TW'(1));
  localparam logic signed [TW-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_FIN, S_DONE} state_t;

  state_t                              state_q, state_d;
  logic                                in_ready_q;
  logic [IW-1:0]                       i_q, i_d;
  logic [JW-1:0]                       j_q, j_d;
  logic signed [AW-1:0]                acc_q, acc_d;
  logic [N_input*BITSIZE-1:0]          x_q;
  logic [N_input*M_output*BITSIZE-1:0] w_q;
  logic [M_output*BITSIZE-1:0]         b_q;
  logic [M_output*BITSIZE-1:0]         y_q, y_d;

  logic                                accept;
  logic                                i_last;
  logic                                j_last;
  logic signed [BITSIZE-1:0]           x_sel, w_sel, b_sel;
  logic signed [PW-1:0]                prod;
  logic signed [AW-1:0]                prod_ext;
  logic signed [TW-1:0]                acc_ext, b_sh, t_sum, t_shr;
  logic [BITSIZE-1:0]                  sat_val, res;

  assign accept = in_valid && in_ready_q && (state_q == S_IDLE);
  assign i_last = (i_q == IW'(N_input - 1));
  assign j_last = (j_q == JW'(M_output - 1));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept)    state_d = S_MAC;
      S_MAC:  if (i_last)    state_d = S_FIN;
      S_FIN:  state_d = j_last ? S_DONE : S_MAC;
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready  = in_ready_q;
    out_valid = (state_q == S_DONE);
    busy      = (state_q == S_MAC) || (state_q == S_FIN);
    y         = y_q;
  end

  assign x_sel = x_q[int'(i_q)*BITSIZE +: BITSIZE];
  assign w_sel = w_q[(int'(j_q)*N_input + int'(i_q))*BITSIZE +: BITSIZE];
  assign b_sel = b_q[int'(j_q)*BITSIZE +: BITSIZE];

  assign prod     = PW'(x_sel) * PW'(w_sel);
  assign prod_ext = {{(AW-PW){prod[PW-1]}}, prod};

  // Bias is aligned to the product's 2*FRAC binary point before rounding
  assign acc_ext = {acc_q[AW-1], acc_q};
  assign b_sh    = {{(TW-BITSIZE){b_sel[BITSIZE-1]}}, b_sel} <<< FRAC;
  assign t_sum   = acc_ext + b_sh + RND;
  assign t_shr   = t_sum >>> FRAC;

  always_comb begin
    sat_val = t_shr[BITSIZE-1:0];
    if (t_shr > SAT_MAX) begin
      sat_val = {1'b0, {(BITSIZE-1){1'b1}}};
    end else if (t_shr < SAT_MIN) begin
      sat_val = {1'b1, {(BITSIZE-1){1'b0}}};
    end
  end

  always_comb begin
    res = sat_val;
`ifdef ENCODER_RELU_EN
    if (sat_val[BITSIZE-1]) res = '0;
`endif
  end

  always_comb begin
    acc_d = acc_q;
    i_d   = i_q;
    j_d   = j_q;
    y_d   = y_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          acc_d = '0;
          i_d   = '0;
          j_d   = '0;
        end
      end
      S_MAC: begin
        acc_d = acc_q + prod_ext;
        if (!i_last) i_d = i_q + 1'b1;
      end
      S_FIN: begin
        y_d[int'(j_q)*BITSIZE +: BITSIZE] = res;
        acc_d = '0;
        i_d   = '0;
        if (!j_last) j_d = j_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ready_q <= 1'b0;
      i_q        <= '0;
      j_q        <= '0;
      acc_q      <= '0;
      x_q        <= '0;
      w_q        <= '0;
      b_q        <= '0;
      y_q        <= '0;
    end else begin
      // Ready is registered so it first rises one edge after reset release
      in_ready_q <= (state_d == S_IDLE);
      i_q        <= i_d;
      j_q        <= j_d;
      acc_q      <= acc_d;
      y_q        <= y_d;
      if (accept) begin
        x_q <= x;
        w_q <= w;
        b_q <= b;
      end
    end
  end

endmodule

// File: tb/tb_encoder_mac_seq.sv
// Scoreboard bench for encoder_mac_seq at default parameters.
module tb_encoder_mac_seq;

  localparam int N  = 9;
  localparam int M  = 4;
  localparam int B  = 32;
  localparam int F  = 16;
  localparam int XW = N * B;
  localparam int WW = N * M * B;
  localparam int YW = M * B;
  localparam int LAT = M * (N + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [XW-1:0] x = '0;
  logic [WW-1:0] w = '0;
  logic [YW-1:0] b = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [YW-1:0] y;
  logic          busy;

  int compared = 0;
  int failed   = 0;
  int cyc      = 0;
  logic [YW-1:0] exp_q[$];

  encoder_mac_seq #(.N_input(N), .M_output(M), .BITSIZE(B), .FRAC(F)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .w(w), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [XW-1:0] fill_n(input logic [B-1:0] v);
    logic [XW-1:0] r;
    for (int i = 0; i < N; i++) r[i*B +: B] = v;
    return r;
  endfunction

  function automatic logic [WW-1:0] fill_nm(input logic [B-1:0] v);
    logic [WW-1:0] r;
    for (int i = 0; i < N*M; i++) r[i*B +: B] = v;
    return r;
  endfunction

  function automatic logic [YW-1:0] fill_m(input logic [B-1:0] v);
    logic [YW-1:0] r;
    for (int i = 0; i < M; i++) r[i*B +: B] = v;
    return r;
  endfunction

  function automatic logic [YW-1:0] model(input logic [XW-1:0] xv, input logic [WW-1:0] wv,
                                          input logic [YW-1:0] bv);
    logic [YW-1:0] r;
    logic signed [127:0] acc;
    logic signed [B-1:0] xi, wi, bj;
    for (int j = 0; j < M; j++) begin
      acc = '0;
      for (int i = 0; i < N; i++) begin
        xi  = xv[i*B +: B];
        wi  = wv[(j*N+i)*B +: B];
        acc = acc + xi * wi;
      end
      bj  = bv[j*B +: B];
      acc = acc + bj * (128'sd1 <<< F);
      acc = acc + (128'sd1 <<< (F-1));
      acc = acc >>> F;
      if (acc > 128'sd2147483647)       r[j*B +: B] = 32'h7FFFFFFF;
      else if (acc < -128'sd2147483648) r[j*B +: B] = 32'h80000000;
      else                              r[j*B +: B] = acc[B-1:0];
`ifdef ENCODER_RELU_EN
      if (r[j*B+B-1]) r[j*B +: B] = '0;
`endif
    end
    return r;
  endfunction

  task automatic send(input logic [XW-1:0] xv, input logic [WW-1:0] wv, input logic [YW-1:0] bv,
                      input logic [YW-1:0] ev, output int acc_cyc);
    int n;
    n = 0;
    x = xv; w = wv; b = bv; in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    compared++;
    if (in_ready !== 1'b1) begin
      failed++;
      $display("FAIL send_ready: in_ready=%b required 1", in_ready);
    end
    @(posedge clk); #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
    exp_q.push_back(ev);
    // Scramble the ports: the captured bundle must be used
    x = ~xv; w = ~wv; b = ~bv;
    compared++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      failed++;
      $display("FAIL accept_state: busy=%b in_ready=%b required 1 0", busy, in_ready);
    end
  endtask

  task automatic recv(input string name, input int acc_cyc, input int lat);
    int n;
    logic [YW-1:0] e;
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1; n++;
    end
    compared++;
    if (out_valid !== 1'b1) begin
      failed++;
      $display("FAIL %s_timeout: out_valid=%b required 1", name, out_valid);
      return;
    end
    if (lat >= 0) begin
      compared++;
      if (cyc - acc_cyc != lat) begin
        failed++;
        $display("FAIL %s_latency: got %0d required %0d", name, cyc - acc_cyc, lat);
      end
    end
    compared++;
    if (exp_q.size() == 0) begin
      failed++;
      $display("FAIL %s_scoreboard: output with no expected entry, y=%h", name, y);
    end else begin
      e = exp_q.pop_front();
      if (y !== e) begin
        failed++;
        $display("FAIL %s_y: got %h required %h", name, y, e);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    compared++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failed++;
      $display("FAIL %s_release: out_valid=%b in_ready=%b required 0 1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    compared++;
    if ({in_ready, out_valid, busy} !== 3'b000 || y !== '0) begin
      failed++;
      $display("FAIL reset_outputs: rdy/vld/busy=%b y=%h required 000 and 0", {in_ready, out_valid, busy}, y);
    end
    rst = 1'b1;
    #1;
    compared++;
    if (in_ready !== 1'b0) begin
      failed++;
      $display("FAIL reset_ready_early: in_ready=%b required 0", in_ready);
    end
    @(posedge clk); #1;
    compared++;
    if (in_ready !== 1'b1) begin
      failed++;
      $display("FAIL reset_ready_edge: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_functional();
    int a;
    send(fill_n(32'h00010000), fill_nm(32'h00008000), '0, fill_m(32'h00048000), a);
    recv("functional", a, LAT);
  endtask

  task automatic test_sign_bias_relu();
    int a;
    logic [XW-1:0] xv;
    logic [WW-1:0] wv;
    logic [YW-1:0] ev;
    xv = '0;
    xv[B-1:0] = 32'hFFFF0000;
    wv = '0;
    for (int j = 0; j < M; j++) wv[(j*N)*B +: B] = 32'h00010000;
`ifdef ENCODER_RELU_EN
    ev = '0;
`else
    ev = fill_m(32'hFFFF8000);
`endif
    send(xv, wv, fill_m(32'h00008000), ev, a);
    recv("sign_bias", a, LAT);
  endtask

  task automatic test_saturation();
    int a;
    send(fill_n(32'h7FFFFFFF), fill_nm(32'h7FFFFFFF), '0, fill_m(32'h7FFFFFFF), a);
    recv("sat_pos", a, LAT);
`ifdef ENCODER_RELU_EN
    send(fill_n(32'h80000000), fill_nm(32'h7FFFFFFF), '0, '0, a);
`else
    send(fill_n(32'h80000000), fill_nm(32'h7FFFFFFF), '0, fill_m(32'h80000000), a);
`endif
    recv("sat_neg", a, LAT);
  endtask

  task automatic test_rounding();
    int a;
    logic [XW-1:0] xv;
    logic [WW-1:0] wv;
    xv = '0;
    xv[B-1:0] = 32'h00000001;
    wv = '0;
    for (int j = 0; j < M; j++) wv[(j*N)*B +: B] = 32'h00008000;
    send(xv, wv, '0, fill_m(32'h00000001), a);
    recv("rounding", a, LAT);
  endtask

  task automatic test_backpressure();
    int a, n;
    logic [YW-1:0] e;
    e = fill_m(32'h00048000);
    send(fill_n(32'h00010000), fill_nm(32'h00008000), '0, e, a);
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1; n++;
    end
    for (int k = 0; k < 10; k++) begin
      if (k == 3) begin
        in_valid = 1'b1;
        x = fill_n(32'h00020000);
      end
      if (k == 6) in_valid = 1'b0;
      compared++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || y !== e) begin
        failed++;
        $display("FAIL bp_hold%0d: vld=%b rdy=%b y=%h required 1 0 %h", k, out_valid, in_ready, y, e);
      end
      @(posedge clk); #1;
    end
    recv("backpressure", a, -1);
    repeat (5) @(posedge clk);
    #1;
    compared++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      failed++;
      $display("FAIL bp_no_capture: busy=%b out_valid=%b required 0 0", busy, out_valid);
    end
  endtask

  task automatic test_reset_abort();
    int a;
    send(fill_n(32'h00010000), fill_nm(32'h00008000), '0, fill_m(32'h00048000), a);
    repeat (15) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    compared++;
    if ({in_ready, out_valid, busy} !== 3'b000 || y !== '0) begin
      failed++;
      $display("FAIL abort_outputs: rdy/vld/busy=%b y=%h required 000 and 0", {in_ready, out_valid, busy}, y);
    end
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    compared++;
    if ({in_ready, out_valid, busy} !== 3'b000 || y !== '0) begin
      failed++;
      $display("FAIL abort_hold: rdy/vld/busy=%b y=%h required 000 and 0", {in_ready, out_valid, busy}, y);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    compared++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failed++;
      $display("FAIL abort_release: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
    send(fill_n(32'h00010000), fill_nm(32'h00008000), '0, fill_m(32'h00048000), a);
    recv("abort_rerun", a, LAT);
  endtask

  task automatic test_back_to_back();
    int a;
    logic [XW-1:0] xv;
    logic [WW-1:0] wv;
    logic [YW-1:0] bv;
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < N; i++) xv[i*B +: B] = $urandom_range(0, 32'h7FFFF) - 32'h40000;
      for (int i = 0; i < N*M; i++) wv[i*B +: B] = $urandom_range(0, 32'h7FFFF) - 32'h40000;
      for (int j = 0; j < M; j++) bv[j*B +: B] = (t == 3) ? $urandom : ($urandom_range(0, 32'h7FFFF) - 32'h40000);
      if (t == 3) for (int i = 0; i < N; i++) xv[i*B +: B] = $urandom;
      send(xv, wv, bv, model(xv, wv, bv), a);
      recv("b2b", a, LAT);
    end
  endtask

  initial begin
    test_reset();
    test_functional();
    test_sign_bias_relu();
    test_saturation();
    test_rounding();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    compared++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/encoder_mac_seq.md
Name: encoder_mac_seq

Overview:
- Sequential, parametrised dense-layer encoder: y[j] = sat(round(sum_i x[i]*w[j][i] + b[j])), for j = 0..M_output-1.
- One shared signed multiplier-accumulator is time-multiplexed over all N_input*M_output products.
- Fraction width is a parameter; results round and saturate.
- Valid/ready handshakes on input and output, so it drops into the encoder pipeline between the input buffer and the latent stage.

Parameters:
- N_input, 9, number of input features.
- M_output, 4, number of output neurons.
- BITSIZE, 32, word width; two's-complement fixed point.
- FRAC, 16, fraction bits (Q(BITSIZE-FRAC).FRAC); legal range 1..BITSIZE-1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  x/w/b bundle valid.
- in_ready  out  1  block can accept a bundle.
- x  in  N_input*BITSIZE  inputs; x[i] = x[i*BITSIZE +: BITSIZE].
- w  in  N_input*M_output*BITSIZE  weights; w[j][i] = w[(j*N_input+i)*BITSIZE +: BITSIZE].
- b  in  M_output*BITSIZE  biases; b[j] = b[j*BITSIZE +: BITSIZE].
- out_valid  out  1  y holds a complete result.
- out_ready  in  1  downstream accepts y.
- y  out  M_output*BITSIZE  results; y[j] = y[j*BITSIZE +: BITSIZE].
- busy  out  1  high in the MAC or FIN state.

Behaviour:
- States: IDLE, MAC, FIN, DONE. Indices: i over 0..N_input-1, j over 0..M_output-1.
- Reset (rst low, asynchronous):
  - state = IDLE, i = j = 0, accumulator = 0.
  - in_ready = 0, out_valid = 0, busy = 0, y = 0.
  - in_ready rises on the first clk edge after rst is released.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: register x, w and b internally, clear accumulator, i = j = 0, go to MAC.
- MAC:
  - One cycle per i: acc += x[i]*w[j][i], a full-precision signed 2*BITSIZE product.
  - Accumulator width is 2*BITSIZE + clog2(N_input) + 1, so it never overflows.
  - Move to FIN after i = N_input-1.
- FIN (one cycle):
  - t = acc + (sign-extended b[j] << FRAC) + (1 << (FRAC-1)).
  - Arithmetic shift right by FRAC (round half up).
  - Saturate to [-2^(BITSIZE-1), 2^(BITSIZE-1)-1] and write into y[j].
  - Clear acc, i = 0.
  - If j = M_output-1, go to DONE; else j++ and go to MAC.
- Latency: out_valid goes high exactly M_output*(N_input+1) cycles after the accepting edge (40 at defaults).
- DONE:
  - out_valid = 1; y is stable until out_valid & out_ready.
  - After that handshake, the next state is IDLE and in_ready = 1 the following cycle.
  - There is no overlap: in_ready = 0 in MAC, FIN and DONE, and in_valid is ignored there.
- y holds its last value in all states except FIN writes. Readers qualify y with out_valid.
- Changes on the x/w/b ports after the accept edge have no effect.
- Reset mid-operation aborts the computation immediately. All outputs take their reset values, and no partial result is ever presented.
- N_input = 1 and M_output = 1 are legal. The latency formula holds for them.

Optional Feature:
- Macro ENCODER_RELU_EN.
- Defined: the FIN stage applies ReLU after saturation; negative results are written as 0.
- Undefined: signed saturated results pass unchanged.
- Latency is identical with or without the macro.

Test Plan:
- Functional and latency: all x = 0x00010000 (1.0), all w = 0x00008000 (0.5), b = 0, defaults -> every y[j] = 0x00048000 (4.5); out_valid rises exactly 40 cycles after the accept edge.
- Sign, bias and ReLU:
  - x[0] = 0xFFFF0000 (-1.0), w[j][0] = 0x00010000, all other w = 0, b[j] = 0x00008000 (0.5).
  - Without ENCODER_RELU_EN -> y[j] = 0xFFFF8000 (-0.5).
  - With ENCODER_RELU_EN -> y[j] = 0x00000000.
- Saturation:
  - All x = w = 0x7FFFFFFF, b = 0 -> all y = 0x7FFFFFFF.
  - All x = 0x80000000, w = 0x7FFFFFFF -> all y = 0x80000000.
- Rounding: x[0] = 0x00000001, w[j][0] = 0x00008000, rest 0, b = 0 -> y[j] = 0x00000001 (half rounds up).
- Backpressure:
  - Hold out_ready = 0 for 10 cycles after out_valid, with in_valid pulsed and x changed during that time.
  - Required: out_valid stays 1, y stays unchanged, in_ready stays 0, and the second bundle is not captured.
  - Raise out_ready -> one transfer, in_ready = 1 the next cycle.
- Reset abort: drive rst low for 2 cycles at cycle 15 of a computation.
  - During reset: all outputs 0.
  - After release: in_ready = 1 on the first edge.
  - The test 1 bundle then reproduces 0x00048000 with 40-cycle latency.
